// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Used by inst_loader and its word_packer; checksum build selected by INST_LOADER_CHECKSUM_EN.
package inst_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        BYTE,
        WRITE,
        CKSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-wide valid/ready stream feeding the loader.
// master = byte source, slave = inst_loader.
interface inst_loader_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/inst_loader_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream (first byte lands in [31:24]).
// full flags the byte that completes the current word, in the cycle it is accepted.
module word_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word  <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            word  <= {word[23:0], byte_in};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign full = shift_en && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Program loader: length-prefixed byte stream -> instruction memory write port, CPU held meanwhile.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LEN_W = DEFAULT_LEN_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    inst_loader_if.slave      bus,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [LEN_W-1:0]  len_q;
    logic [31:0]       addr_q;
    logic [15:0]       len_full;
    logic              xfer;
    logic              load_start;
    logic              last_word;
    logic              pack_shift;
    logic              pack_full;
    logic [31:0]       pack_word;

    assign len_full   = {len_hi_q, bus.byte_in};
    assign xfer       = bus.byte_valid && bus.byte_ready;
    assign load_start = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign last_word  = (addr_q + 32'd1) == 32'(len_q);
    assign pack_shift = (state_q == BYTE) && bus.byte_valid;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            csum_q <= '0;
        end else if (pack_shift) begin
            csum_q <= csum_q ^ bus.byte_in;
        end
    end
`endif

    word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (load_start),
        .shift_en (pack_shift),
        .byte_in  (bus.byte_in),
        .word     (pack_word),
        .full     (pack_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        bus.byte_ready = 1'b0;
        busy           = 1'b0;
        mem_we         = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LEN_HI;
            end
            LEN_HI: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) state_d = LEN_LO;
            end
            LEN_LO: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) begin
                    if (32'(len_full) > DEPTH_U) state_d = ERR;
                    else if (len_full == 16'd0)  state_d = DONE;
                    else                         state_d = BYTE;
                end
            end
            BYTE: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (pack_full) state_d = WRITE;
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                state_d = last_word ? CKSUM : BYTE;
`else
                state_d = last_word ? DONE : BYTE;
`endif
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CKSUM: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) state_d = (bus.byte_in == csum_q) ? DONE : ERR;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_d = LEN_HI;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_d = LEN_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address restarts at 0 per load and advances once per WRITE; N <= DEPTH keeps it in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi_q <= '0;
            len_q    <= '0;
            addr_q   <= '0;
        end else begin
            if (load_start)             addr_q <= '0;
            else if (state_q == WRITE)  addr_q <= addr_q + 32'd1;
            if (state_q == LEN_HI && xfer) len_hi_q <= bus.byte_in;
            if (state_q == LEN_LO && xfer) len_q    <= LEN_W'(len_full);
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = pack_word;
    assign cpu_hold  = busy;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of whole-stream loads plus hand-written corner sequences.
// Checksum cases compile in when INST_LOADER_CHECKSUM_EN is defined for the bench as well.
module tb_inst_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    inst_loader_if bus ();

    inst_loader #(.DEPTH(64), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Write log captured from the memory port.
    logic [31:0] wr_addr [0:127];
    logic [31:0] wr_data [0:127];
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 128) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    typedef struct {
        string       name;
        int          nb;
        logic [7:0]  b [0:13];
        bit          toggle;
        bit          exp_done;
        bit          exp_error;
        int          exp_writes;
        logic [31:0] w [0:2];
    } vec_t;

    vec_t vec [0:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        if (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (bus.byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        bus.byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_finish_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_mem_we"},    32'(mem_we),         32'd0);
        check({name, "_mem_addr"},  mem_addr,            32'd0);
        check({name, "_mem_wdata"}, mem_wdata,           32'd0);
        check({name, "_busy"},      32'(busy),           32'd0);
        check({name, "_done"},      32'(done),           32'd0);
        check({name, "_error"},     32'(error),          32'd0);
        check({name, "_cpu_hold"},  32'(cpu_hold),       32'd0);
        check({name, "_ready"},     32'(bus.byte_ready), 32'd0);
    endtask

    initial begin
        logic [7:0]  x;
        logic [31:0] w;
        int          bad;

        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;

        vec[0].name = "n2_basic";   vec[0].nb = 10; vec[0].toggle = 0;
        vec[0].b    = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'hFF, 8'hFF,
                        8'h00, 8'h00, 8'h00, 8'h00};
        vec[0].exp_done = 1; vec[0].exp_error = 0; vec[0].exp_writes = 2;
        vec[0].w    = '{32'h2008_0005, 32'h2129_FFFF, 32'h0};

        vec[1].name = "len_too_big"; vec[1].nb = 2; vec[1].toggle = 0;
        vec[1].b    = '{8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00};
        vec[1].exp_done = 0; vec[1].exp_error = 1; vec[1].exp_writes = 0;
        vec[1].w    = '{32'h0, 32'h0, 32'h0};

        vec[2].name = "n1_recover"; vec[2].nb = 6; vec[2].toggle = 0;
        vec[2].b    = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00};
        vec[2].exp_done = 1; vec[2].exp_error = 0; vec[2].exp_writes = 1;
        vec[2].w    = '{32'hDEAD_BEEF, 32'h0, 32'h0};

        vec[3].name = "n0_empty";   vec[3].nb = 2; vec[3].toggle = 0;
        vec[3].b    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00};
        vec[3].exp_done = 1; vec[3].exp_error = 0; vec[3].exp_writes = 0;
        vec[3].w    = '{32'h0, 32'h0, 32'h0};

        vec[4].name = "n3_toggle";  vec[4].nb = 14; vec[4].toggle = 1;
        vec[4].b    = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                        8'h99, 8'hAA, 8'hBB, 8'hCC};
        vec[4].exp_done = 1; vec[4].exp_error = 0; vec[4].exp_writes = 3;
        vec[4].w    = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven whole-stream loads
        for (int v = 0; v < 5; v++) begin
            wr_cnt = 0;
            pulse_start();
            x = 8'h00;
            for (int i = 0; i < vec[v].nb; i++) begin
                send_byte(vec[v].b[i], vec[v].toggle);
                if (i >= 2) x = x ^ vec[v].b[i];
            end
`ifdef INST_LOADER_CHECKSUM_EN
            if (vec[v].exp_done && vec[v].nb > 2) send_byte(x, vec[v].toggle);
`endif
            wait_finish(vec[v].name);
            check({vec[v].name, "_done"},     32'(done),           32'(vec[v].exp_done));
            check({vec[v].name, "_error"},    32'(error),          32'(vec[v].exp_error));
            check({vec[v].name, "_busy"},     32'(busy),           32'd0);
            check({vec[v].name, "_cpu_hold"}, 32'(cpu_hold),       32'd0);
            check({vec[v].name, "_ready"},    32'(bus.byte_ready), 32'd0);
            check({vec[v].name, "_writes"},   32'(wr_cnt),         32'(vec[v].exp_writes));
            for (int i = 0; i < vec[v].exp_writes; i++) begin
                check($sformatf("%s_addr%0d", vec[v].name, i), wr_addr[i], 32'(i));
                check($sformatf("%s_data%0d", vec[v].name, i), wr_data[i], vec[v].w[i]);
            end
        end

        // mem_we timing: high in the cycle after the 4th byte edge, done/busy one cycle later
        wr_cnt = 0;
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
        check("start_done_cleared", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        check("timing_pre_we", 32'(mem_we), 32'd0);
        send_byte(8'hD4, 0);
        check("timing_we_high", 32'(mem_we), 32'd1);
        check("timing_we_addr", mem_addr, 32'd0);
        check("timing_we_data", mem_wdata, 32'hA1B2_C3D4);
        check("timing_we_ready", 32'(bus.byte_ready), 32'd0);
        @(posedge clk);
        #1;
        check("timing_we_low", 32'(mem_we), 32'd0);
`ifndef INST_LOADER_CHECKSUM_EN
        check("timing_done_next", 32'(done), 32'd1);
        check("timing_busy_fell", 32'(busy), 32'd0);
`else
        send_byte(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4, 0);
        wait_finish("timing_cksum");
        check("timing_cksum_done", 32'(done), 32'd1);
`endif
        check("timing_writes", 32'(wr_cnt), 32'd1);

        // Reset mid-load after 6 data bytes of N=4, then a fresh load from address 0
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        check("midrst_writes_before", 32'(wr_cnt), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hBA, 0);
        send_byte(8'hBE, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE, 0);
`endif
        wait_finish("midrst_restart");
        check("midrst_restart_done", 32'(done), 32'd1);
        check("midrst_restart_writes", 32'(wr_cnt), 32'd1);
        check("midrst_restart_addr", wr_addr[0], 32'd0);
        check("midrst_restart_data", wr_data[0], 32'hCAFE_BABE);

        // N == DEPTH fills every word; a start pulse mid-load must be ignored
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        x = 8'h00;
        for (int k = 0; k < 64; k++) begin
            w = {8'(k), 8'h5A, 8'hC3, ~8'(k)};
            for (int j = 3; j >= 0; j--) begin
                send_byte(w[j*8 +: 8], 0);
                x = x ^ w[j*8 +: 8];
            end
            if (k == 10) pulse_start();
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
        wait_finish("full_depth");
        check("full_depth_done", 32'(done), 32'd1);
        check("full_depth_error", 32'(error), 32'd0);
        check("full_depth_writes", 32'(wr_cnt), 32'd64);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (wr_addr[k] !== 32'(k) || wr_data[k] !== {8'(k), 8'h5A, 8'hC3, ~8'(k)}) bad++;
        end
        check("full_depth_bad_words", 32'(bad), 32'd0);
        check("full_depth_last_addr", wr_addr[63], 32'd63);

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum match and mismatch on N=1, data 01 02 03 04
        for (int c = 0; c < 2; c++) begin
            wr_cnt = 0;
            pulse_start();
            send_byte(8'h00, 0);
            send_byte(8'h01, 0);
            send_byte(8'h01, 0);
            send_byte(8'h02, 0);
            send_byte(8'h03, 0);
            send_byte(8'h04, 0);
            send_byte((c == 0) ? 8'h04 : 8'h05, 0);
            wait_finish("cksum");
            check($sformatf("cksum%0d_done", c), 32'(done), (c == 0) ? 32'd1 : 32'd0);
            check($sformatf("cksum%0d_error", c), 32'(error), (c == 0) ? 32'd0 : 32'd1);
            check($sformatf("cksum%0d_writes", c), 32'(wr_cnt), 32'd1);
            check($sformatf("cksum%0d_data", c), wr_data[0], 32'h0102_0304);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
